// File: rtl/grom_switch_input.sv
// -----------------------------------------------------------------------------
// grom_switch_input
//
// Input-side peripheral for the grom8 board. The raw push-button levels are
// synchronised and debounced. Each debounced transition becomes an event byte.
// Event bytes are queued in a small first-word-fall-through FIFO, and the CPU
// drains that FIFO. The debounced levels are also exported for LEDs and status.
//
// Event byte layout:
//   bit7    : 1 = press, 0 = release
//   bits6:2 : 0
//   bits1:0 : switch index
//
// Optional feature (compile-time macro GROM_SWITCH_RELEASE_EVENTS_EN):
//   defined   - release transitions are queued as events with bit7 = 0
//   undefined - only presses are queued; a release updates o_Level only
//
// Parameters:
//   DEBOUNCE_CYCLES : number of consecutive stable synchronised cycles needed
//                     to accept a level change (must be >= 4)
//   FIFO_DEPTH      : number of event queue entries (power of 2, >= 2)
//   NUM_SWITCHES    : number of button inputs (1..4)
//
// Ports:
//   i_Clk      : main clock
//   i_Reset_n  : asynchronous, active-low reset
//   i_Switch   : raw button levels, 1 = pressed, asynchronous to i_Clk
//   i_Rd       : pop request
//   i_Clr_Ovf  : clears o_Overflow
//   o_Data     : head event byte, 8'h00 when the queue is empty
//   o_Valid    : queue is non-empty
//   o_Overflow : sticky flag; set when an event was dropped
//   o_Level    : debounced switch levels
//
// Read handshake: o_Valid/i_Rd follow valid/ready semantics. o_Data always
// shows the head entry. An entry is consumed on every rising clock edge where
// both o_Valid and i_Rd are high. If i_Rd is high while o_Valid is low, the
// request is ignored and no state changes.
// -----------------------------------------------------------------------------
module grom_switch_input #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int FIFO_DEPTH      = 4,
   parameter int NUM_SWITCHES    = 4
) (
   input  logic                    i_Clk,
   input  logic                    i_Reset_n,
   input  logic [NUM_SWITCHES-1:0] i_Switch,
   input  logic                    i_Rd,
   input  logic                    i_Clr_Ovf,
   output logic [7:0]              o_Data,
   output logic                    o_Valid,
   output logic                    o_Overflow,
   output logic [NUM_SWITCHES-1:0] o_Level
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

   // ---------------------------------------------------------------------------
   // Two-flop synchroniser
   // ---------------------------------------------------------------------------
   logic [NUM_SWITCHES-1:0] sync1;
   logic [NUM_SWITCHES-1:0] sync2;

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= i_Switch;
         sync2 <= sync1;
      end
   end

   // ---------------------------------------------------------------------------
   // Debounce
   // Each switch has a counter of consecutive cycles in which sync2 differed
   // from the accepted (stable) level. If sync2 returns to the stable level,
   // the counter clears, so a glitch shorter than DEBOUNCE_CYCLES leaves no
   // trace.
   // ---------------------------------------------------------------------------
   logic [NUM_SWITCHES-1:0] stable;
   logic [NUM_SWITCHES-1:0] accept;
   logic [DB_W-1:0]         db_cnt [NUM_SWITCHES];

   always_comb begin
      accept = '0;
      for (int i = 0; i < NUM_SWITCHES; i++) begin
         accept[i] = (sync2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         stable <= '0;
         for (int i = 0; i < NUM_SWITCHES; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SWITCHES; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (accept[i]) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Event generation
   // set_pend marks the switches whose accepted transition creates an event
   // in this cycle.
   // ---------------------------------------------------------------------------
   logic [NUM_SWITCHES-1:0] set_pend;
   logic [NUM_SWITCHES-1:0] pending;
   logic [NUM_SWITCHES-1:0] grant;
   logic [1:0]              push_idx;
   logic                    push;
   logic [7:0]              push_data;
   logic                    push_press;

`ifdef GROM_SWITCH_RELEASE_EVENTS_EN
   // Stores the direction of each pending event. A switch can hold only one
   // pending event at a time. The arbiter drains it long before the
   // debouncer can accept the next transition on the same switch.
   logic [NUM_SWITCHES-1:0] evt_type;

   assign set_pend = accept;

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         evt_type <= '0;
      end else begin
         for (int i = 0; i < NUM_SWITCHES; i++) begin
            if (accept[i]) begin
               evt_type[i] <= sync2[i];
            end
         end
      end
   end

   always_comb begin
      push_press = 1'b0;
      for (int i = 0; i < NUM_SWITCHES; i++) begin
         if (grant[i]) begin
            push_press = evt_type[i];
         end
      end
   end
`else
   // Only rising transitions (presses) produce events.
   assign set_pend   = accept & sync2;
   assign push_press = 1'b1;
`endif

   // ---------------------------------------------------------------------------
   // Fixed-priority arbiter
   // Each cycle, the lowest-index pending switch is granted. At most one
   // event is pushed per cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      grant    = '0;
      push_idx = 2'd0;
      for (int i = NUM_SWITCHES - 1; i >= 0; i--) begin
         if (pending[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            push_idx = 2'(i);
         end
      end
   end

   assign push      = |pending;
   assign push_data = {push_press, 5'b00000, push_idx};

   // A granted flag is cleared even if the FIFO is full and the event is
   // dropped. A new acceptance in the same cycle takes priority.
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~grant) | set_pend;
      end
   end

   // ---------------------------------------------------------------------------
   // FWFT event FIFO
   // The occupancy count is kept separately from the pointers, so full and
   // empty never depend on comparing pointers. A push into an empty FIFO
   // becomes visible one cycle later; it is never bypassed to the output in
   // the same cycle.
   // ---------------------------------------------------------------------------
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             wr_en;
   logic             drop;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FIFO_FULL);
   assign pop        = i_Rd && !fifo_empty;
   // When the FIFO is full, a pop in the same cycle frees a slot for the push.
   assign wr_en      = push && (!fifo_full || pop);
   assign drop       = push && fifo_full && !pop;

   always_ff @(posedge i_Clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag. If a drop and a clear happen in the same cycle,
   // the drop wins.
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         o_Overflow <= 1'b0;
      end else if (drop) begin
         o_Overflow <= 1'b1;
      end else if (i_Clr_Ovf) begin
         o_Overflow <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_Valid = !fifo_empty;
   assign o_Data  = fifo_empty ? 8'h00 : mem[rd_ptr];
   assign o_Level = stable;

endmodule
